// File: rtl/register_file_bank.sv
// ---------------------------------------------------------------------------
// register_file_bank
//   DEPTH = 2**ADDR_W entries of DATA_W bits, one write port and two
//   registered read ports. A sequential clear zeroes one entry per cycle,
//   and reset always starts one. When ZERO_REG is nonzero, entry 0 is
//   hard-wired to read as zero.
//
//   Optional feature (macro REGFILE_BYPASS_EN):
//     defined   - an IDLE write that hits the address being read is forwarded
//                 to that read port in the same cycle.
//     undefined - that read returns the value held before the write.
//
// Ports
//   inp_clk        clock, rising edge
//   inp_rst        synchronous active-high reset; starts a full clear
//   inp_clear      one-cycle request to start a sequential clear
//   inp_flagWrite  write enable
//   inp_regWrite   write address
//   inp_dataWrite  write data
//   inp_rs         read address, port 1
//   inp_rd         read address, port 2
//   out_readData1  registered read data, port 1
//   out_readData2  registered read data, port 2
//   out_busy       high while a clear sequence is running
// ---------------------------------------------------------------------------
module register_file_bank #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_clear,
  input  logic              inp_flagWrite,
  input  logic [ADDR_W-1:0] inp_regWrite,
  input  logic [DATA_W-1:0] inp_dataWrite,
  input  logic [ADDR_W-1:0] inp_rs,
  input  logic [ADDR_W-1:0] inp_rd,
  output logic [DATA_W-1:0] out_readData1,
  output logic [DATA_W-1:0] out_readData2,
  output logic              out_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  // The counter is one bit wider than the address, so stepping past the last
  // entry never aliases back onto entry 0.
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;

  function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write takes effect only in IDLE, outside reset, and never targets a
  // hard-wired zero entry.
  assign wr_ok = !inp_rst && (state_q == IDLE) && inp_flagWrite &&
                 !is_zero_entry(inp_regWrite);

  always_comb begin
    rd1_d = is_zero_entry(inp_rs) ? '0 : mem_q[inp_rs];
    rd2_d = is_zero_entry(inp_rd) ? '0 : mem_q[inp_rd];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (inp_regWrite == inp_rs)) rd1_d = inp_dataWrite;
    if (wr_ok && (inp_regWrite == inp_rd)) rd2_d = inp_dataWrite;
`endif
  end

  // Control FSM and registered read outputs
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd1_q <= rd1_d;
          rd2_q <= rd2_d;
          if (inp_clear) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CLEAR: begin
          // A clear request arriving here is ignored; the sequence runs on.
          rd1_q <= '0;
          rd2_q <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: only the clear sequence and accepted writes modify it.
  always_ff @(posedge inp_clk) begin
    if (!inp_rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_ok) begin
        mem_q[inp_regWrite] <= inp_dataWrite;
      end
    end
  end

  assign out_readData1 = rd1_q;
  assign out_readData2 = rd2_q;
  assign out_busy      = busy_q;

endmodule

// File: tb/tb_register_file_bank.sv
module tb_register_file_bank;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int ZERO_REG = 1;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              we  = 1'b0;
  logic [ADDR_W-1:0] wa  = '0;
  logic [DATA_W-1:0] wd  = '0;
  logic [ADDR_W-1:0] rs  = '0;
  logic [ADDR_W-1:0] rd  = '0;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic              b;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: contents, and how far a clear has progressed.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int clear_left = 0;
  int clear_pos  = 0;
  int cyc_no     = 0;

  register_file_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) dut (
    .inp_clk(clk), .inp_rst(rst), .inp_clear(clr),
    .inp_flagWrite(we), .inp_regWrite(wa), .inp_dataWrite(wd),
    .inp_rs(rs), .inp_rd(rd),
    .out_readData1(rdata1), .out_readData2(rdata2), .out_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ref_read(input int a, input logic w_en,
                                                 input int w_a, input logic [DATA_W-1:0] w_d);
    if (ZERO_REG != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w_en && w_a == a) return w_d;
`endif
    return ref_mem[a];
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic cyc(input logic r, input logic c, input logic w, input int a_w,
                     input logic [DATA_W-1:0] d_w, input int a_s, input int a_d);
    exp_t e;
    @(negedge clk);
    rst = r; clr = c; we = w;
    wa = ADDR_W'(a_w); wd = d_w; rs = ADDR_W'(a_s); rd = ADDR_W'(a_d);
    cyc_no++;
    e.cyc = cyc_no;
    if (r) begin
      clear_left = DEPTH; clear_pos = 0;
      e.r1 = '0; e.r2 = '0; e.b = 1'b1;
    end else if (clear_left > 0) begin
      ref_mem[clear_pos] = '0;
      clear_pos++; clear_left--;
      e.r1 = '0; e.r2 = '0; e.b = (clear_left > 0);
    end else begin
      logic w_eff;
      w_eff = w && !(ZERO_REG != 0 && a_w == 0);
      e.r1 = ref_read(a_s, w_eff, a_w, d_w);
      e.r2 = ref_read(a_d, w_eff, a_w, d_w);
      if (w_eff) ref_mem[a_w] = d_w;
      if (c) begin clear_left = DEPTH; clear_pos = 0; end
      e.b = c;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int a_s, input int a_d);
    cyc(1'b0, 1'b0, 1'b0, 0, '0, a_s, a_d);
  endtask

  // Monitor: every edge produces an output; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata1 !== e.r1) begin
          errors++;
          $display("FAIL rd1 cycle %0d: got %h expected %h", e.cyc, rdata1, e.r1);
        end
        checks++;
        if (rdata2 !== e.r2) begin
          errors++;
          $display("FAIL rd2 cycle %0d: got %h expected %h", e.cyc, rdata2, e.r2);
        end
        checks++;
        if (busy !== e.b) begin
          errors++;
          $display("FAIL busy cycle %0d: got %b expected %b", e.cyc, busy, e.b);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset pulse then eight busy cycles, then every entry reads zero.
    cyc(1'b1, 1'b0, 1'b0, 0, '0, 0, 0);
    for (int i = 0; i < DEPTH; i++) idle(i, DEPTH - 1 - i);
    for (int i = 0; i < DEPTH; i++) idle(i, (i + 3) % DEPTH);

    // Write then read on both ports.
    cyc(1'b0, 1'b0, 1'b1, 5, 16'hBEEF, 1, 2);
    idle(5, 5);
    idle(5, 4);

    // Entry 0 is hard-wired to zero.
    cyc(1'b0, 1'b0, 1'b1, 0, 16'h1234, 0, 0);
    idle(0, 0);

    // Same-cycle write and read of entry 3.
    cyc(1'b0, 1'b0, 1'b1, 3, 16'h0F0F, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 3, 16'hA5A5, 3, 2);
    idle(3, 3);

    // Fill everything, clear, and attempt a write mid-clear.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, i, 16'h1100 + 16'(i), i, i);
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 6, 7);
    cyc(1'b0, 1'b0, 1'b1, 2, 16'h7777, 2, 2);
    cyc(1'b0, 1'b1, 1'b1, 4, 16'h4444, 4, 1);
    for (int i = 0; i < DEPTH; i++) idle(2, i);

    // Reset in the middle of a clear restarts the full sequence.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, i, 16'h2200 + 16'(i), 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) idle(1, 2);
    cyc(1'b1, 1'b1, 1'b1, 6, 16'h6666, 6, 6);
    for (int i = 0; i < DEPTH; i++) idle(i, i);
    for (int i = 0; i < DEPTH; i++) idle(i, DEPTH - 1 - i);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, c, w;
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 31) == 0);
      w = ($urandom_range(0, 1) == 1);
      cyc(r, c, w, $urandom_range(0, DEPTH - 1), DATA_W'($urandom),
          $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
    end
    idle(0, 0);

    // Let the monitor consume the final expectation.
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
